// File: rtl/mainfsm.sv
// mainfsm: multicycle processor main control FSM; define MAINFSM_STATE_OUT_EN to expose the State port
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc
`ifdef MAINFSM_STATE_OUT_EN
  ,
  output logic [3:0] State
`endif
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;
  state_t s;
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
  // State transitions; Op/Funct only matter in DECODE and MEMADR, unused codes fall back to FETCH
  always_ff @(posedge clk) begin
    if (reset) s <= FETCH;
    else
      case (s)
        FETCH:              s <= DECODE;
        DECODE:             s <= Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                 Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : FETCH;
        MEMADR:             s <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:              s <= MEMWB;
        EXECUTER, EXECUTEI: s <= ALUWB;
        default:            s <= FETCH;
      endcase
  end
  // Moore output decode from the state register only; unused codes decode to all zeros
  always_comb begin
    IRWrite   = s == FETCH;
    NextPC    = s == FETCH;
    AdrSrc    = s == MEMRD || s == MEMWR;
    ALUSrcA   = s == FETCH || s == DECODE;
    ALUOp     = s == EXECUTER || s == EXECUTEI;
    RegW      = s == MEMWB || s == ALUWB;
    MemW      = s == MEMWR;
    Branch    = s == BRANCH;
    ALUSrcB   = (s == FETCH || s == DECODE) ? 2'b10 :
                (s == MEMADR || s == EXECUTEI || s == BRANCH) ? 2'b01 : 2'b00;
    ResultSrc = (s == FETCH || s == DECODE || s == BRANCH) ? 2'b10 :
                s == MEMWB ? 2'b01 : 2'b00;
  end
`ifdef MAINFSM_STATE_OUT_EN
  assign State = s;
`endif
endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: path/table reference model bench for mainfsm with directed and random instruction streams
module tb_mainfsm;
  logic clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc;
  int total = 0, bad = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp),
    .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch} per state number
  logic [11:0] otab [10];
  initial begin
    otab[0] = {1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    otab[1] = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    otab[2] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    otab[3] = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    otab[4] = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    otab[5] = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    otab[6] = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    otab[7] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    otab[8] = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    otab[9] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  end

  logic [11:0] got;
  assign got = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};

  logic s_rst;
  logic [1:0] s_op;
  logic [5:0] s_f;
  always @(posedge clk) begin
    s_rst <= reset;
    s_op  <= Op;
    s_f   <= Funct;
  end

  // Reference model: the remaining path of the current instruction is a queue of state numbers
  int exp_st = 0, pend = 0, dcnt = 0;
  int q[$];
  bit valid = 0;
  initial forever begin
    @(negedge clk);
    if (s_rst === 1'b1) begin
      exp_st = 0; q.delete(); valid = 1; pend = 0;
    end else if (valid) begin
      if (exp_st == 0) exp_st = 1;
      else begin
        if (exp_st == 1) begin
          q.delete();
          if (s_op == 2'b00) begin q.push_back(s_f[5] ? 7 : 6); q.push_back(8); pend = 4; end
          else if (s_op == 2'b01) q.push_back(2);
          else if (s_op == 2'b10) begin q.push_back(9); pend = 3; end
          else pend = 2;
        end else if (exp_st == 2) begin
          if (s_f[0]) begin q.push_back(3); q.push_back(4); pend = 5; end
          else begin q.push_back(5); pend = 4; end
        end
        exp_st = q.size() > 0 ? q.pop_front() : 0;
      end
    end
    if (valid) begin
      total++;
      if (got !== otab[exp_st]) begin
        bad++;
        $display("FAIL outs t=%0t state=%0d got=%b exp=%b", $time, exp_st, got, otab[exp_st]);
      end
      dcnt++;
      if (IRWrite === 1'b1) begin
        if (pend > 0) begin
          total++;
          if (dcnt != pend) begin
            bad++;
            $display("FAIL latency t=%0t got=%0d exp=%0d", $time, dcnt, pend);
          end
        end
        dcnt = 0; pend = 0;
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] g, input logic [3:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] f, input int n);
    Op = op; Funct = f;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1; Op = 2'b11; Funct = 6'd0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    lit("reset_irwrite", {3'b0, IRWrite}, 4'h1);
    lit("reset_nextpc", {3'b0, NextPC}, 4'h1);
    lit("reset_alusrcb", {2'b0, ALUSrcB}, 4'h2);
    lit("reset_resultsrc", {2'b0, ResultSrc}, 4'h2);
    lit("reset_regw_memw", {2'b0, RegW, MemW}, 4'h0);
    @(posedge clk); #2;
    lit("decode_irwrite", {3'b0, IRWrite}, 4'h0);
    lit("decode_alusrca", {3'b0, ALUSrcA}, 4'h1);
    @(posedge clk); #2;
    instr(2'b01, 6'b000001, 5);
    instr(2'b01, 6'b000000, 4);
    instr(2'b00, 6'b000000, 4);
    instr(2'b00, 6'b100000, 4);
    instr(2'b10, 6'b000000, 3);
    instr(2'b11, 6'b000000, 2);
    Op = 2'b01; Funct = 6'b000001;
    repeat (3) @(posedge clk);
    #2;
    lit("memrd_adrsrc", {3'b0, AdrSrc}, 4'h1);
    reset = 1;
    @(posedge clk); #2 reset = 0;
    lit("midreset_regw", {3'b0, RegW}, 4'h0);
    lit("midreset_irwrite", {3'b0, IRWrite}, 4'h1);
    repeat (3000) begin
      Op = 2'($urandom);
      Funct = 6'($urandom);
      reset = $urandom_range(0, 59) == 0;
      @(posedge clk); #2;
    end
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
